lag_measure: RTL and testbench

LAG_MEASURE -- requirements
Module: lag_measure

---
 rtl/lag_measure.sv | 210 +++++++++++++++++++++
 tb/tb_lag_measure.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lag_measure.sv
// Display lag meter: times the interval from a video start trigger to the first
// debounced light edge seen by a photo-sensor, and keeps min/max/count statistics.
module lag_measure #(
    parameter int unsigned TICKS_PER_US = 27,
    parameter int unsigned DEBOUNCE     = 16,
    parameter int unsigned TIMEOUT_US   = 500000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        starttrigger,
    input  logic        sensor,
    input  logic        clear_stats,
    output logic        busy,
    output logic        lag_valid,
    output logic        timeout,
    output logic [19:0] lag_us,
    output logic [19:0] lag_min_us,
    output logic [19:0] lag_max_us,
    output logic [7:0]  sample_count,
    output logic        sensor_level
);

    localparam int unsigned LAG_W = 20;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned PRE_W = 8;
    localparam int unsigned DEB_W = 8;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_US - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
    localparam logic [LAG_W-1:0] US_LIMIT = LAG_W'(TIMEOUT_US);
    localparam logic [LAG_W-1:0] LAG_ONES = {LAG_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    // Sensor path registers
    logic             sync1_q, sync2_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic             edge_c;

    // Measurement FSM and counters
    state_e           state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [LAG_W-1:0] us_q, us_d;
    logic             capture_c;

    // Registered outputs
    logic             busy_q, busy_d;
    logic             lag_valid_q, lag_valid_d;
    logic             timeout_q, timeout_d;
    logic [LAG_W-1:0] lag_q, lag_d;
    logic [LAG_W-1:0] min_q, min_d, min_base;
    logic [LAG_W-1:0] max_q, max_d, max_base;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

    // Two-flop synchronizer, debounce counter and previous level for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            deb_cnt_q    <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync1_q      <= sensor;
            sync2_q      <= sync1_q;
            deb_cnt_q    <= deb_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    // Accept the synchronized level once it has differed for DEBOUNCE consecutive cycles
    always_comb begin
        deb_cnt_d = '0;
        level_d   = level_q;
        if (sync2_q != level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                level_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Rising edge is visible in the first cycle sensor_level reads 1
    assign edge_c = level_q & ~level_prev_q;

    // State and counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            us_q    <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            us_q    <= us_d;
        end
    end

    // Next state: edge beats retrigger beats timeout; edge+trigger restarts after capturing
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        us_d        = us_q;
        capture_c   = 1'b0;
        lag_valid_d = 1'b0;
        timeout_d   = 1'b0;
        lag_d       = lag_q;
        case (state_q)
            IDLE: begin
                if (starttrigger) begin
                    state_d = MEASURE;
                    presc_d = '0;
                    us_d    = '0;
                end
            end
            MEASURE: begin
                if (presc_q == PRE_LAST) begin
                    presc_d = '0;
                    if (us_q != US_LIMIT) begin
                        us_d = us_q + LAG_W'(1);
                    end
                end else begin
                    presc_d = presc_q + PRE_W'(1);
                end

                if (edge_c) begin
                    capture_c   = 1'b1;
                    lag_valid_d = 1'b1;
                    lag_d       = us_q;
                    if (starttrigger) begin
                        presc_d = '0;
                        us_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (starttrigger) begin
                    presc_d = '0;
                    us_d    = '0;
                end else if (us_q == US_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == MEASURE);
    end

    // Statistics: a coincident clear is applied before the capture is folded in
    always_comb begin
        min_base = clear_stats ? LAG_ONES : min_q;
        max_base = clear_stats ? '0 : max_q;
        cnt_base = clear_stats ? '0 : cnt_q;
        min_d    = min_base;
        max_d    = max_base;
        cnt_d    = cnt_base;
        if (capture_c) begin
            if (us_q < min_base) begin
                min_d = us_q;
            end
            if (us_q > max_base) begin
                max_d = us_q;
            end
            if (cnt_base != CNT_SAT) begin
                cnt_d = cnt_base + CNT_W'(1);
            end
        end
    end

    // Output and statistics registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q      <= 1'b0;
            lag_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            lag_q       <= '0;
            min_q       <= LAG_ONES;
            max_q       <= '0;
            cnt_q       <= '0;
        end else begin
            busy_q      <= busy_d;
            lag_valid_q <= lag_valid_d;
            timeout_q   <= timeout_d;
            lag_q       <= lag_d;
            min_q       <= min_d;
            max_q       <= max_d;
            cnt_q       <= cnt_d;
        end
    end

    assign busy         = busy_q;
    assign lag_valid    = lag_valid_q;
    assign timeout      = timeout_q;
    assign lag_us       = lag_q;
    assign lag_min_us   = min_q;
    assign lag_max_us   = max_q;
    assign sample_count = cnt_q;
    assign sensor_level = level_q;

endmodule

// File: tb/tb_lag_measure.sv
// Directed bench for lag_measure with TICKS_PER_US=4, DEBOUNCE=3, TIMEOUT_US=100.
module tb_lag_measure;

    localparam int unsigned TPU = 4;
    localparam int unsigned DEB = 3;
    localparam int unsigned TO  = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        starttrigger;
    logic        sensor;
    logic        clear_stats;
    logic        busy;
    logic        lag_valid;
    logic        timeout;
    logic [19:0] lag_us;
    logic [19:0] lag_min_us;
    logic [19:0] lag_max_us;
    logic [7:0]  sample_count;
    logic        sensor_level;

    int errors = 0;
    int checks = 0;
    int lv_cnt = 0;
    int to_cnt = 0;
    int exp_lv = 0;
    int exp_to = 0;

    lag_measure #(
        .TICKS_PER_US(TPU),
        .DEBOUNCE    (DEB),
        .TIMEOUT_US  (TO)
    ) dut (
        .clock       (clk),
        .reset_n     (rst_n),
        .starttrigger(starttrigger),
        .sensor      (sensor),
        .clear_stats (clear_stats),
        .busy        (busy),
        .lag_valid   (lag_valid),
        .timeout     (timeout),
        .lag_us      (lag_us),
        .lag_min_us  (lag_min_us),
        .lag_max_us  (lag_max_us),
        .sample_count(sample_count),
        .sensor_level(sensor_level)
    );

    always #5 clk = ~clk;

    // Count output pulses mid-cycle
    always @(negedge clk) begin
        if (lag_valid === 1'b1) lv_cnt++;
        if (timeout === 1'b1) to_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles; land 1 time unit after the rising edge
    task automatic tick_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse starttrigger; returns in elapsed tick 0 of the measurement
    task automatic trig();
        starttrigger = 1'b1;
        tick_wait(1);
        starttrigger = 1'b0;
    endtask

    task automatic clr();
        clear_stats = 1'b1;
        tick_wait(1);
        clear_stats = 1'b0;
    endtask

    // From tick 0, raise the sensor so the debounced edge lands on tick e; return in tick e+1
    task automatic run_edge(input int e);
        tick_wait(e - 5);
        sensor = 1'b1;
        tick_wait(6);
    endtask

    task automatic release_sensor();
        sensor = 1'b0;
        tick_wait(8);
    endtask

    task automatic check_stats(input string tag, input logic [19:0] lag,
                               input logic [19:0] mn, input logic [19:0] mx,
                               input logic [7:0] cnt);
        check({tag, "_lag"}, 32'(lag_us), 32'(lag));
        check({tag, "_min"}, 32'(lag_min_us), 32'(mn));
        check({tag, "_max"}, 32'(lag_max_us), 32'(mx));
        check({tag, "_cnt"}, 32'(sample_count), 32'(cnt));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_lv"}, 32'(lag_valid), 32'd0);
        check({tag, "_to"}, 32'(timeout), 32'd0);
        check({tag, "_lvl"}, 32'(sensor_level), 32'd0);
        check_stats(tag, 20'd0, 20'hFFFFF, 20'd0, 8'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        starttrigger = 1'b0;
        sensor       = 1'b0;
        clear_stats  = 1'b0;
        tick_wait(3);
        check_reset("reset");
        rst_n = 1'b1;
        tick_wait(2);

        // Edge at tick 41 -> 10 us
        trig();
        check("a_busy0", 32'(busy), 32'd1);
        tick_wait(36);
        sensor = 1'b1;
        tick_wait(5);
        check("a_lvl41", 32'(sensor_level), 32'd1);
        check("a_lv41", 32'(lag_valid), 32'd0);
        tick_wait(1);
        check("a_lv42", 32'(lag_valid), 32'd1);
        check("a_busy42", 32'(busy), 32'd0);
        check_stats("a", 20'd10, 20'd10, 20'd10, 8'd1);
        exp_lv++;
        tick_wait(1);
        check("a_lv43", 32'(lag_valid), 32'd0);
        release_sensor();
        check("a_lvl_fall", 32'(sensor_level), 32'd0);
        check("a_lvcnt", 32'(lv_cnt), 32'(exp_lv));

        // Timeout after 400 ticks with no edge
        trig();
        tick_wait(400);
        check("b_to400", 32'(timeout), 32'd0);
        check("b_busy400", 32'(busy), 32'd1);
        tick_wait(1);
        check("b_to401", 32'(timeout), 32'd1);
        check("b_busy401", 32'(busy), 32'd0);
        check_stats("b", 20'd10, 20'd10, 20'd10, 8'd1);
        exp_to++;
        tick_wait(1);
        check("b_to402", 32'(timeout), 32'd0);
        check("b_tocnt", 32'(to_cnt), 32'(exp_to));

        // Two-cycle glitch is rejected; stable high at tick 20 gives edge at 25 -> 6 us
        trig();
        tick_wait(10);
        sensor = 1'b1;
        tick_wait(2);
        sensor = 1'b0;
        tick_wait(8);
        check("c_glitch_lvl", 32'(sensor_level), 32'd0);
        check("c_glitch_busy", 32'(busy), 32'd1);
        check("c_glitch_lvcnt", 32'(lv_cnt), 32'(exp_lv));
        sensor = 1'b1;
        tick_wait(6);
        check("c_lv", 32'(lag_valid), 32'd1);
        check_stats("c", 20'd6, 20'd6, 20'd10, 8'd2);
        exp_lv++;
        release_sensor();
        clr();
        check_stats("c_clr", 20'd6, 20'hFFFFF, 20'd0, 8'd0);

        // Captures of 10, 5, 20
        trig();
        run_edge(41);
        check("d_lag10", 32'(lag_us), 32'd10);
        release_sensor();
        trig();
        run_edge(21);
        check("d_lag5", 32'(lag_us), 32'd5);
        release_sensor();
        trig();
        run_edge(81);
        check("d_lag20", 32'(lag_us), 32'd20);
        release_sensor();
        exp_lv += 3;
        check_stats("d", 20'd20, 20'd5, 20'd20, 8'd3);
        clr();
        check_stats("d_clr", 20'd20, 20'hFFFFF, 20'd0, 8'd0);

        // Clear coinciding with a capture at tick 12 -> 3 us
        trig();
        tick_wait(7);
        sensor = 1'b1;
        tick_wait(5);
        clear_stats = 1'b1;
        tick_wait(1);
        clear_stats = 1'b0;
        check("cc_lv", 32'(lag_valid), 32'd1);
        check_stats("cc", 20'd3, 20'd3, 20'd3, 8'd1);
        exp_lv++;
        release_sensor();

        // Retrigger at tick 20, edge 8 ticks later -> 2 us
        trig();
        tick_wait(20);
        trig();
        check("e_busy", 32'(busy), 32'd1);
        check("e_lv", 32'(lag_valid), 32'd0);
        check("e_to", 32'(timeout), 32'd0);
        run_edge(8);
        check("e_lv9", 32'(lag_valid), 32'd1);
        check_stats("e", 20'd2, 20'd2, 20'd3, 8'd2);
        exp_lv++;
        release_sensor();
        check("e_lvcnt", 32'(lv_cnt), 32'(exp_lv));
        check("e_tocnt", 32'(to_cnt), 32'(exp_to));

        // Edge while idle is ignored
        sensor = 1'b1;
        tick_wait(8);
        check("i_lvl", 32'(sensor_level), 32'd1);
        check("i_busy", 32'(busy), 32'd0);
        check_stats("i", 20'd2, 20'd2, 20'd3, 8'd2);
        release_sensor();
        check("i_lvcnt", 32'(lv_cnt), 32'(exp_lv));

        // Edge exactly at the timeout tick wins
        trig();
        run_edge(400);
        check("t_lv", 32'(lag_valid), 32'd1);
        check("t_to", 32'(timeout), 32'd0);
        check("t_busy", 32'(busy), 32'd0);
        check_stats("t", 20'd100, 20'd2, 20'd100, 8'd3);
        exp_lv++;
        tick_wait(1);
        check("t_to_next", 32'(timeout), 32'd0);
        release_sensor();
        check("t_tocnt", 32'(to_cnt), 32'(exp_to));

        // Edge and trigger together: capture 3 us and keep measuring
        trig();
        tick_wait(7);
        sensor = 1'b1;
        tick_wait(5);
        starttrigger = 1'b1;
        tick_wait(1);
        starttrigger = 1'b0;
        check("f_lv", 32'(lag_valid), 32'd1);
        check("f_busy", 32'(busy), 32'd1);
        check_stats("f", 20'd3, 20'd2, 20'd100, 8'd4);
        exp_lv++;
        release_sensor();
        check("f_busy_after", 32'(busy), 32'd1);

        // Reset at tick 30 of a fresh measurement
        trig();
        tick_wait(30);
        rst_n = 1'b0;
        #2;
        check_reset("g");
        tick_wait(2);
        rst_n = 1'b1;
        tick_wait(450);
        check("g_busy", 32'(busy), 32'd0);
        check("g_lvcnt", 32'(lv_cnt), 32'(exp_lv));
        check("g_tocnt", 32'(to_cnt), 32'(exp_to));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
